storage_job_scheduler: RTL and testbench

Queues store/fetch jobs from the three location sources (barcode scanner, voice UART, manual address switches) and issues them one at a time to the motion sequencer that drives the extend/rise/rotate axes. Round-robin arbitration feeds a small FIFO. A dispatch FSM starts each job, waits for completion or timeout, and keeps a 16-slot occupancy map. It sits between the address decoders and the motion sequencer, and replaces direct key-press start of the sequencer.

---
 rtl/storage_job_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_storage_job_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_job_scheduler.sv
// Round-robin job queue and dispatch FSM between the location decoders and the motion sequencer.
// Optional macro SCHED_OCCUPANCY_CHECK_EN builds the slot occupancy map and its store/fetch checks.
module storage_job_scheduler #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               req_valid,
  input  logic [14:0]              req_addr,
  input  logic [2:0]               req_op,
  output logic [2:0]               req_ready,
  output logic                     job_start,
  output logic [4:0]               job_addr,
  output logic                     job_op,
  input  logic                     job_done,
  input  logic                     alarm_clr,
  output logic                     busy,
  output logic                     alarm,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [25:0] TMO = 26'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT_DONE, ALARM} state_t;
  typedef struct packed {
    logic [4:0] addr;
    logic       op;
  } job_t;

  state_t          state_q, state_d;
  job_t            mem_q [DEPTH];
  job_t            cur_q, cur_d, push_job;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      rr_q, rr_d, s0, s1, s2, gsel;
  logic [25:0]     tmo_q, tmo_d;
  logic [4:0]      job_addr_q, job_addr_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            job_start_q, job_start_d, job_op_q, job_op_d;
  logic            busy_q, busy_d, alarm_q, alarm_d, err_q, err_d;
  logic            push, pop, full, gok;
`ifdef SCHED_OCCUPANCY_CHECK_EN
  logic [15:0]     occ_q, occ_d;
  logic [3:0]      slot;
  assign slot = 4'(cur_q.addr - 5'd1);
`endif

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Grant scans the sources starting just after the last accepted one.
  always_comb begin
    full = (cnt_q == CW'(DEPTH));
    s0   = nxt(rr_q);
    s1   = nxt(s0);
    s2   = nxt(s1);
    gsel = rr_q;
    gok  = 1'b0;
    if (req_valid[s0]) begin
      gsel = s0; gok = 1'b1;
    end else if (req_valid[s1]) begin
      gsel = s1; gok = 1'b1;
    end else if (req_valid[s2]) begin
      gsel = s2; gok = 1'b1;
    end
    if (full) gok = 1'b0;
    req_ready     = gok ? (3'b001 << gsel) : 3'b000;
    push          = gok;
    rr_d          = gok ? gsel : rr_q;
    push_job.addr = req_addr[5*gsel +: 5];
    push_job.op   = req_op[gsel];
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    tmo_d       = tmo_q;
    rd_d        = rd_q;
    pop         = 1'b0;
    job_start_d = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    job_addr_d  = job_addr_q;
    job_op_d    = job_op_q;
`ifdef SCHED_OCCUPANCY_CHECK_EN
    occ_d       = occ_q;
`endif
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop     = 1'b1;
        cur_d   = mem_q[rd_q];
        rd_d    = rd_q + 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (cur_q.addr == 5'd0 || cur_q.addr > 5'd16) begin
          err_d = 1'b1; err_code_d = 2'd1; state_d = IDLE;
        end
`ifdef SCHED_OCCUPANCY_CHECK_EN
        else if (!cur_q.op && occ_q[slot]) begin
          err_d = 1'b1; err_code_d = 2'd2; state_d = IDLE;
        end else if (cur_q.op && !occ_q[slot]) begin
          err_d = 1'b1; err_code_d = 2'd3; state_d = IDLE;
        end
`endif
        else begin
          job_start_d = 1'b1;
          job_addr_d  = cur_q.addr;
          job_op_d    = cur_q.op;
          tmo_d       = '0;
          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        // Completion wins over a timeout landing on the same edge.
        if (job_done) begin
`ifdef SCHED_OCCUPANCY_CHECK_EN
          occ_d[slot] = !cur_q.op;
`endif
          state_d = IDLE;
        end else if (tmo_d >= TMO) begin
          state_d = ALARM;
        end
      end
      ALARM: if (alarm_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == CHECK) || (state_d == WAIT_DONE);
    alarm_d = (state_d == ALARM);
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_job;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      rr_q        <= 2'd2;
      tmo_q       <= '0;
      job_start_q <= 1'b0;
      job_addr_q  <= '0;
      job_op_q    <= 1'b0;
      busy_q      <= 1'b0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
`ifdef SCHED_OCCUPANCY_CHECK_EN
      occ_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      tmo_q       <= tmo_d;
      job_start_q <= job_start_d;
      job_addr_q  <= job_addr_d;
      job_op_q    <= job_op_d;
      busy_q      <= busy_d;
      alarm_q     <= alarm_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
`ifdef SCHED_OCCUPANCY_CHECK_EN
      occ_q       <= occ_d;
`endif
    end
  end

  assign job_start  = job_start_q;
  assign job_addr   = job_addr_q;
  assign job_op     = job_op_q;
  assign busy       = busy_q;
  assign alarm      = alarm_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign fifo_count = cnt_q;
`ifdef SCHED_OCCUPANCY_CHECK_EN
  assign occupancy  = occ_q;
`else
  assign occupancy  = '0;
`endif
endmodule

// File: tb/tb_storage_job_scheduler.sv
// Directed bench for storage_job_scheduler: queue/phase reference model checked every cycle,
// plus literal expectations at the points called out for each scenario.
module tb_storage_job_scheduler;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;
`ifdef SCHED_OCCUPANCY_CHECK_EN
  localparam bit OCC = 1'b1;
`else
  localparam bit OCC = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [2:0]  req_valid = '0, req_op = '0, req_ready;
  logic [14:0] req_addr = '0;
  logic        job_start, job_op, busy, alarm, err;
  logic        job_done = 1'b0, alarm_clr = 1'b0;
  logic [4:0]  job_addr;
  logic [1:0]  err_code;
  logic [2:0]  fifo_count;
  logic [15:0] occupancy;

  always #5 clk = ~clk;

  storage_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op),
    .req_ready(req_ready), .job_start(job_start), .job_addr(job_addr), .job_op(job_op),
    .job_done(job_done), .alarm_clr(alarm_clr), .busy(busy), .alarm(alarm), .err(err),
    .err_code(err_code), .fifo_count(fifo_count), .occupancy(occupancy));

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a job queue plus the phase of the job in hand (0 idle, 1 check, 2 running, 3 alarm).
  typedef struct { int addr; int op; } mjob_t;
  mjob_t       mq[$];
  mjob_t       mcur, mj;
  int          mph, mptr, cyc, t_start, m_addr, m_code, mg, cg;
  bit          m_start, m_err, m_op;
  logic [15:0] mocc;

  function automatic int m_grant();
    if (mq.size() == DEPTH) return -1;
    for (int k = 1; k <= 3; k++) begin
      if (req_valid[(mptr + k) % 3]) return (mptr + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); mph = 0; mptr = 2; cyc = 0; t_start = 0; mocc = '0;
      m_start = 0; m_err = 0; m_code = 0; m_addr = 0; m_op = 0;
    end else begin
      mg = m_grant();
      cyc++;
      m_start = 0; m_err = 0;
      case (mph)
        0: if (mq.size() > 0) begin mcur = mq.pop_front(); mph = 1; end
        1: begin
          if (mcur.addr == 0 || mcur.addr > 16) begin m_err = 1; m_code = 1; mph = 0; end
          else if (OCC && mcur.op == 0 && mocc[mcur.addr-1]) begin m_err = 1; m_code = 2; mph = 0; end
          else if (OCC && mcur.op == 1 && !mocc[mcur.addr-1]) begin m_err = 1; m_code = 3; mph = 0; end
          else begin m_start = 1; m_addr = mcur.addr; m_op = mcur.op[0]; t_start = cyc; mph = 2; end
        end
        2: if (job_done) begin mocc[mcur.addr-1] = (mcur.op == 0); mph = 0; end
           else if (cyc - t_start >= TMO) mph = 3;
        default: if (alarm_clr) mph = 0;
      endcase
      if (mg >= 0) begin
        mj.addr = int'(req_addr[5*mg +: 5]); mj.op = int'(req_op[mg]);
        mq.push_back(mj); mptr = mg;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    cg = m_grant();
    chk("req_ready", req_ready, (cg < 0) ? 0 : (1 << cg));
    chk("job_start", job_start, m_start);
    chk("job_addr", job_addr, m_addr);
    chk("job_op", job_op, m_op);
    chk("busy", busy, (mph == 1 || mph == 2));
    chk("alarm", alarm, (mph == 3));
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
    chk("fifo_count", fifo_count, mq.size());
    chk("occupancy", occupancy, OCC ? mocc : 16'h0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input int src, input int addr, input int op);
    req_valid = 3'b001 << src;
    req_addr = '0; req_addr[5*src +: 5] = 5'(addr);
    req_op = '0; req_op[src] = op[0];
    #1 chk("req_grant", req_ready, 3'b001 << src);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic pulse_done();
    job_done = 1'b1;
    @(posedge clk); #1;
    job_done = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      if (job_start) break;
      @(posedge clk); #1;
    end
    chk("start_seen", job_start, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_job_start"}, job_start, 0);
    chk({tag, "_job_addr"}, job_addr, 0);
    chk({tag, "_job_op"}, job_op, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, starts;
    #3 chk_all_zero("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic store to slot 5
    request(0, 5, 0);
    tick(2);
    chk("basic_start", job_start, 1);
    chk("basic_addr", job_addr, 5);
    chk("basic_op", job_op, 0);
    chk("basic_busy", busy, 1);
    pulse_done();
    chk("basic_busy_done", busy, 0);
    chk("basic_occ", occupancy, OCC ? 16'h0010 : 16'h0);

    // round robin while a job from source 2 runs
    request(2, 1, 0);
    tick(2);
    chk("rr_hold_start", job_start, 1);
    req_valid = 3'b111; req_addr = {5'd4, 5'd3, 5'd2}; req_op = '0;
    #1 chk("rr_g0", req_ready, 3'b001);
    @(posedge clk); #1 chk("rr_g1", req_ready, 3'b010);
    @(posedge clk); #1 chk("rr_g2", req_ready, 3'b100);
    @(posedge clk); #1 req_valid = '0;
    chk("rr_count", fifo_count, 3);
    pulse_done();
    repeat (3) begin wait_start(); pulse_done(); end
    chk("rr_occ", occupancy, OCC ? 16'h001F : 16'h0);

    // fill the FIFO behind a running job
    request(0, 6, 0);
    tick(2);
    chk("full_hold_start", job_start, 1);
    req_valid = 3'b001; req_op = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 15'(11 + i);
      #1 chk("fill_ready", req_ready, 3'b001);
      @(posedge clk); #1;
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", req_ready, 3'b000);
    req_valid = '0;
    pulse_done();
    req_valid = 3'b001; req_addr = 15'd15;
    #1 chk("full_ready_done", req_ready, 3'b000);
    @(posedge clk); #1 chk("full_ready_back", req_ready, 3'b001);
    chk("full_count_pop", fifo_count, 3);
    req_valid = '0;
    repeat (4) begin wait_start(); pulse_done(); end
    chk("full_occ", occupancy, OCC ? 16'h3C3F : 16'h0);

    // rejects
    request(0, 0, 0);
    tick(2);
    chk("rej0_err", err, 1);
    chk("rej0_code", err_code, 1);
    chk("rej0_start", job_start, 0);
    tick(1);
    request(1, 9, 1);
    tick(2);
    chk("rej9_err", err, OCC);
    chk("rej9_code", err_code, OCC ? 3 : 1);
    chk("rej9_start", job_start, !OCC);
    if (job_start) pulse_done();
    request(2, 7, 0);
    tick(2);
    chk("st7a_start", job_start, 1);
    pulse_done();
    request(0, 7, 0);
    tick(2);
    chk("st7b_err", err, OCC);
    chk("st7b_code", err_code, OCC ? 2 : 1);
    if (job_start) pulse_done();
    tick(1);

    // timeout with a second job queued behind
    request(0, 16, 0);
    tick(2);
    chk("tmo_start", job_start, 1);
    request(1, 15, 0);
    k = 1;
    while (!alarm && k < 40) begin @(posedge clk); #1; k++; end
    chk("tmo_edges", k, TMO);
    chk("tmo_alarm", alarm, 1);
    chk("tmo_busy", busy, 0);
    alarm_clr = 1'b1;
    @(posedge clk); #1 alarm_clr = 1'b0;
    chk("tmo_cleared", alarm, 0);
    wait_start();
    chk("tmo_next_addr", job_addr, 15);
    pulse_done();
    chk("tmo_occ", occupancy, OCC ? 16'h7C7F : 16'h0);

    // reset in the middle of a job with two queued
    request(0, 8, 0);
    tick(2);
    chk("rst_job_start", job_start, 1);
    req_valid = 3'b110; req_addr = {5'd10, 5'd9, 5'd0}; req_op = '0;
    @(posedge clk); @(posedge clk); #1 req_valid = '0;
    chk("rst_queued", fifo_count, 2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #3 rst_n = 1'b1;
    starts = 0;
    repeat (10) begin @(posedge clk); #1 if (job_start) starts++; end
    chk("post_rst_starts", starts, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
